// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// Holds the FSM state enum, data-bits codes and width/mask helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] DB5 = 2'd0;
  localparam logic [1:0] DB6 = 2'd1;
  localparam logic [1:0] DB7 = 2'd2;
  localparam logic [1:0] DB8 = 2'd3;

  function automatic logic [3:0] data_bits_n(input logic [1:0] code);
    logic [3:0] n;
    unique case (code)
      DB5:     n = 4'd5;
      DB6:     n = 4'd6;
      DB7:     n = 4'd7;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] code);
    return 8'hFF >> (4'd8 - data_bits_n(code));
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous 8-bit FIFO, DEPTH entries, wrap pointers with extra MSB.
// Ports: clk, rst_n, push/din, pop/dout (show-ahead), full, empty, level.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        do_push;
  logic        do_pop;

  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign level   = wp - rp;
  assign dout    = mem[rp[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5-8 data bits, opt. parity, 1/2 stops.
// Ports: cfg_* frame setup, s_valid/s_data/s_ready in, tx/busy/tx_done out.
module uart_tx_cfg #(
  parameter int DIV_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              cfg_clk_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  input  logic                          s_valid,
  input  logic [7:0]                    s_data,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import uart_pkg::*;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       word_q;
  logic [1:0]       nb_q;
  logic             par_en_q;
  logic             par_q;
  logic             stop2_q;

  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             bit_end;
  logic             last_bit;
  logic             last_stop;

  assign s_ready   = !fifo_full;
  assign push      = s_valid && !fifo_full;
  assign bit_end   = (cnt == div_q - 1'b1);
  assign last_bit  = ({1'b0, bit_idx} == data_bits_n(nb_q) - 4'd1);
  assign last_stop = !stop2_q || stop_idx;
  assign pop       = !fifo_empty &&
                     ((state == S_IDLE) ||
                      (state == S_STOP && bit_end && last_stop));

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (s_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Frame snapshot: word and config are frozen for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      nb_q     <= DB8;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      div_q    <= DIV_W'(1);
    end else if (pop) begin
      word_q   <= fifo_dout & data_mask(cfg_data_bits);
      nb_q     <= cfg_data_bits;
      par_en_q <= cfg_parity_en;
      par_q    <= ^(fifo_dout & data_mask(cfg_data_bits))
                  ^ cfg_parity_odd;
      stop2_q  <= cfg_stop2;
      div_q    <= (cfg_clk_div == '0) ? DIV_W'(1)
                                      : cfg_clk_div;
    end
  end

  // Outputs are registered from the current state, so the line
  // trails the state register by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      cnt     <= bit_end ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          cnt  <= '0;
          if (pop) state <= S_START;
        end
        S_START: begin
          tx      <= 1'b0;
          busy    <= 1'b1;
          bit_idx <= '0;
          if (bit_end) state <= S_DATA;
        end
        S_DATA: begin
          tx   <= word_q[bit_idx];
          busy <= 1'b1;
          if (bit_end) begin
            bit_idx <= bit_idx + 3'd1;
            if (last_bit) begin
              stop_idx <= 1'b0;
              state    <= par_en_q ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          tx   <= par_q;
          busy <= 1'b1;
          if (bit_end) begin
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          tx   <= 1'b1;
          busy <= 1'b1;
          if (bit_end) begin
            if (last_stop) begin
              tx_done <= 1'b1;
              state   <= pop ? S_START : S_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
